// File: rtl/store_write_sequencer.sv
// Store write-data sequencer: word stores go straight to memory, byte/halfword
// stores run a read-modify-write of the target word with little-endian lane merge.
module store_write_sequencer #(
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int LANE_SEL = 0,
    localparam int OFF_W   = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        store_size,
    input  logic [OFF_W-1:0]  addr_off,
    input  logic [DATA_W-1:0] reg_B_data,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mux_wd_memory_out,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int         NUM_LANES = DATA_W / 8;
    localparam logic [2:0] CNT_LAST  = 3'(MEM_LAT - 1);

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_ERR
    } state_t;

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [1:0]        r_size;
    logic [OFF_W-1:0]  r_off;
    logic [15:0]       r_bdata;
    logic [DATA_W-1:0] r_wdata;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic [OFF_W-1:0]  w_lane_lo;
    logic [OFF_W-1:0]  w_lane_hi;
    logic [DATA_W-1:0] w_merged;
    logic              w_reject;

    // Legacy mode pins sub-word data to lane 0 regardless of the offset.
    assign w_lane_lo = (LANE_SEL != 0) ? r_off : '0;
    assign w_lane_hi = w_lane_lo + OFF_W'(1);

    assign w_reject = (store_size == SZ_RSVD) ||
                      ((LANE_SEL != 0) && (store_size == SZ_HALF) && addr_off[0]);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic w_hit_lo;
            logic w_hit_hi;
            assign w_hit_lo = (w_lane_lo == OFF_W'(gi));
            assign w_hit_hi = (r_size == SZ_HALF) && (w_lane_hi == OFF_W'(gi));
            assign w_merged[8*gi +: 8] = w_hit_lo ? r_bdata[7:0]  :
                                         w_hit_hi ? r_bdata[15:8] :
                                                    mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 3'd0;
            r_size   <= 2'b00;
            r_off    <= '0;
            r_bdata  <= 16'd0;
            r_wdata  <= '0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_size  <= store_size;
                        r_off   <= addr_off;
                        r_bdata <= reg_B_data[15:0];
                        r_busy  <= 1'b1;
                        if (w_reject) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end else if (store_size == SZ_WORD) begin
                            r_state  <= S_WRITE;
                            r_wdata  <= reg_B_data;
                            r_mem_wr <= 1'b1;
                            r_done   <= 1'b1;
                        end else begin
                            r_state  <= S_READ;
                            r_mem_rd <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_WAIT;
                    r_cnt   <= 3'd0;
                end
                S_WAIT: begin
                    // Read data is valid on the last WAIT cycle, MEM_LAT after READ.
                    if (r_cnt == CNT_LAST) begin
                        r_state  <= S_WRITE;
                        r_wdata  <= w_merged;
                        r_mem_wr <= 1'b1;
                        r_done   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd            = r_mem_rd;
    assign mem_wr            = r_mem_wr;
    assign mux_wd_memory_out = r_wdata;
    assign busy              = r_busy;
    assign done              = r_done;
    assign err               = r_err;

endmodule

// File: tb/tb_store_write_sequencer.sv
// Bench for store_write_sequencer: four parameterisations share one clock; each store
// is predicted from byte-level rules and checked cycle by cycle.
module tb_store_write_sequencer;

    function automatic int dw_of(input int k);
        return (k == 3) ? 64 : 32;
    endfunction
    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? 3 : 2;
    endfunction
    function automatic int lsel_of(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    logic        clk = 1'b0;
    logic        rstn_v  [4];
    logic        start_v [4];
    logic [1:0]  size_v  [4];
    logic [2:0]  off_v   [4];
    logic [63:0] b_v     [4];
    logic [63:0] rd_v    [4];
    logic        mem_rd_v[4];
    logic        mem_wr_v[4];
    logic        busy_v  [4];
    logic        done_v  [4];
    logic        err_v   [4];
    logic [63:0] wd_v    [4];
    logic [63:0] last_wd [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            logic [dw_of(gi)-1:0] w_wd;
            store_write_sequencer #(
                .DATA_W  (dw_of(gi)),
                .MEM_LAT (lat_of(gi)),
                .LANE_SEL(lsel_of(gi))
            ) u_dut (
                .clk              (clk),
                .reset            (rstn_v[gi]),
                .start            (start_v[gi]),
                .store_size       (size_v[gi]),
                .addr_off         (off_v[gi][$clog2(dw_of(gi)/8)-1:0]),
                .reg_B_data       (b_v[gi][dw_of(gi)-1:0]),
                .mem_rdata        (rd_v[gi][dw_of(gi)-1:0]),
                .mem_rd           (mem_rd_v[gi]),
                .mem_wr           (mem_wr_v[gi]),
                .mux_wd_memory_out(w_wd),
                .busy             (busy_v[gi]),
                .done             (done_v[gi]),
                .err              (err_v[gi])
            );
            assign wd_v[gi] = 64'(w_wd);
        end
    endgenerate

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input int k, input string tag, input logic rd_e, input logic wr_e,
                            input logic err_e, input logic busy_e, input logic [63:0] wd_e);
        chk({tag, " mem_rd"}, 64'(mem_rd_v[k]), 64'(rd_e));
        chk({tag, " mem_wr"}, 64'(mem_wr_v[k]), 64'(wr_e));
        chk({tag, " done"},   64'(done_v[k]),   64'(wr_e));
        chk({tag, " err"},    64'(err_v[k]),    64'(err_e));
        chk({tag, " busy"},   64'(busy_v[k]),   64'(busy_e));
        chk({tag, " wdata"},  wd_v[k],          wd_e);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Called at a falling edge with the DUT idle; returns at the falling edge of the
    // first idle cycle after the store so the next store can follow back-to-back.
    task automatic run_store(input int k, input logic [1:0] sz, input logic [2:0] off,
                             input logic [63:0] b, input logic [63:0] word, input bit poke,
                             input string tag);
        int          lat   = lat_of(k);
        int          nbyte;
        int          lane;
        int          n_cyc;
        bit          is_err;
        bit          is_full;
        logic [63:0] mask;
        logic [63:0] exp_wd;
        logic [63:0] cur_wd;

        mask    = (dw_of(k) == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        is_err  = (sz == 2'b11) || (lsel_of(k) != 0 && sz == 2'b01 && off[0]);
        is_full = (sz == 2'b00);
        lane    = (lsel_of(k) != 0) ? int'(off) : 0;
        nbyte   = (sz == 2'b10) ? 1 : 2;
        if (is_full) begin
            exp_wd = b & mask;
        end else begin
            exp_wd = word & mask;
            for (int i = 0; i < nbyte; i++) exp_wd[8*(lane+i) +: 8] = b[8*i +: 8];
        end
        if (is_err) exp_wd = last_wd[k];
        n_cyc = (is_err || is_full) ? 1 : 2 + lat;

        start_v[k] = 1'b1;
        size_v[k]  = sz;
        off_v[k]   = off;
        b_v[k]     = b;
        rd_v[k]    = rnd64();
        for (int c = 1; c <= n_cyc + 1; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1 || (poke && c == 3)) begin
                start_v[k] = 1'b0;
                size_v[k]  = 2'($urandom_range(0, 3));
                off_v[k]   = 3'($urandom_range(0, 7));
                b_v[k]     = rnd64();
            end
            if (poke && c == 2) begin
                start_v[k] = 1'b1;
                size_v[k]  = 2'b00;
                b_v[k]     = rnd64();
            end
            rd_v[k] = (!is_err && !is_full && c == 1 + lat) ? word : rnd64();
            cur_wd  = (c >= n_cyc && !is_err) ? exp_wd : last_wd[k];
            chk_ctrl(k, $sformatf("%s c%0d", tag, c),
                     !is_err && !is_full && c == 1,
                     !is_err && c == n_cyc,
                     is_err && c == 1,
                     c <= n_cyc,
                     cur_wd);
        end
        last_wd[k] = exp_wd;
        $display("store %s: inst=%0d size=%0d off=%0d b=%h word=%h -> %s %h", tag, k, sz, off,
                 b & mask, word & mask, is_err ? "err" : "wr", exp_wd);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rstn_v[k]  = 1'b1;
            start_v[k] = 1'b0;
            size_v[k]  = 2'b00;
            off_v[k]   = 3'd0;
            b_v[k]     = 64'd0;
            rd_v[k]    = 64'd0;
            last_wd[k] = 64'd0;
        end
        #1;
        for (int k = 0; k < 4; k++) rstn_v[k] = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) chk_ctrl(k, $sformatf("reset inst%0d", k), 0, 0, 0, 0, 64'd0);
        for (int k = 0; k < 4; k++) rstn_v[k] = 1'b1;
        @(negedge clk);

        // Word store, then a back-to-back word store, then a legacy byte store.
        run_store(1, 2'b00, 3'd0, 64'h0000_0000_DEAD_BEEF, 64'd0, 0, "word");
        run_store(1, 2'b00, 3'd1, 64'h0000_0000_0123_4567, 64'd0, 0, "word_b2b");
        run_store(1, 2'b10, 3'd2, 64'h0000_0000_0000_00A5, 64'h1122_3344, 0, "legacy_byte");
        run_store(1, 2'b01, 3'd3, 64'h0000_0000_0000_BEEF, 64'h5566_7788, 0, "legacy_half");

        run_store(2, 2'b01, 3'd2, 64'h0000_0000_0000_CAFE, 64'h1122_3344, 0, "idx_half");
        run_store(2, 2'b01, 3'd1, 64'h0000_0000_0000_CAFE, 64'h1122_3344, 0, "misaligned_half");
        run_store(2, 2'b10, 3'd1, 64'h0000_0000_0000_0055, 64'hAABB_CCDD, 1, "busy_ignore");

        run_store(3, 2'b10, 3'd7, 64'h0000_0000_0000_007F, 64'd0, 0, "byte64_top");
        run_store(3, 2'b11, 3'd0, 64'h0000_0000_0000_0001, 64'd0, 0, "reserved");
        run_store(3, 2'b01, 3'd6, 64'h0000_0000_0000_1234, 64'h0102_0304_0506_0708, 0, "half64_top");

        // Reset during WAIT aborts the store; no strobe afterwards.
        run_store(0, 2'b00, 3'd0, 64'h0000_0000_A5A5_5A5A, 64'd0, 0, "pre_reset");
        start_v[0] = 1'b1;
        size_v[0]  = 2'b10;
        off_v[0]   = 3'd1;
        b_v[0]     = 64'h0000_0000_0000_0099;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn_v[0] = 1'b0;
        #1;
        chk_ctrl(0, "mid_reset", 0, 0, 0, 0, 64'd0);
        last_wd[0] = 64'd0;
        @(negedge clk);
        rstn_v[0] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk_ctrl(0, $sformatf("post_reset c%0d", c), 0, 0, 0, 0, 64'd0);
        end
        $display("store mid_reset: inst=0 aborted during WAIT");

        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < 4; k++) begin
                run_store(k, 2'($urandom_range(0, 3)), 3'($urandom_range(0, dw_of(k)/8 - 1)),
                          rnd64(), rnd64(), bit'($urandom_range(0, 1)) && 1'b0,
                          $sformatf("rand%0d", n));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
